step_rx: RTL and testbench

STEP_RX -- requirements
Module: step_rx

---
 rtl/step_rx_if.sv | 18 +
 rtl/step_rx.sv | 119 +++++++++++
 tb/tb_step_rx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/step_rx_if.sv
// Handshake bundle for the step-pulse receiver: stimulus in, burst status out.
interface step_rx_if #(
  parameter int NUM_COUNT = 5
) ();
  localparam int CW = $clog2(NUM_COUNT + 1);

  logic          STEP;
  logic          ARM;
  logic [CW-1:0] COUNT;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [1:0]    ERR_CODE;
  logic [2:0]    STATE;

  modport master (output STEP, ARM, input COUNT, BUSY, DONE, ERR, ERR_CODE, STATE);
  modport slave  (input STEP, ARM, output COUNT, BUSY, DONE, ERR, ERR_CODE, STATE);
endinterface

// File: rtl/step_rx.sv
// Step-pulse burst receiver: counts STEP rising edges after ARM, enforcing a
// minimum spacing and an inactivity timeout, with sticky error reporting.
module step_rx #(
  parameter int NUM_COUNT = 5,
  parameter int MIN_GAP   = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic      CLK,
  input  logic      RST,
  step_rx_if.slave  bus
);
  localparam int CW = $clog2(NUM_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  // Timer holds cycles since the accepting clock minus one, so interval = r_timer + 1.
  localparam logic [TW-1:0] GAP_M1 = TW'(MIN_GAP - 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_timer;
  logic          r_step_q;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_code;

  logic          w_edge;
  logic          w_tmo;
  logic          w_gap_ok;
  logic          w_last;
  logic [CW-1:0] w_count_inc;
  logic [TW-1:0] w_timer_inc;

  assign w_edge      = bus.STEP & ~r_step_q;
  assign w_tmo       = (r_timer >= TMO_M1);
  assign w_gap_ok    = (r_timer >= GAP_M1);
  assign w_count_inc = r_count + CW'(1);
  assign w_last      = (w_count_inc == CW'(NUM_COUNT));
  assign w_timer_inc = (r_timer == TMO_MX) ? r_timer : r_timer + TW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_timer  <= '0;
      r_step_q <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= 2'b00;
    end else begin
      r_step_q <= bus.STEP;
      r_done   <= 1'b0;
      if (bus.ARM) begin
        r_state <= S_ARMED;
        r_busy  <= 1'b1;
        r_count <= '0;
        r_err   <= 1'b0;
        r_code  <= 2'b00;
        r_timer <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_busy <= 1'b0;
            if (w_edge) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
              r_code  <= 2'b11;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_ARMED, S_RUN: begin
            if (w_edge && (r_state == S_ARMED || w_gap_ok)) begin
              r_count <= (r_state == S_ARMED) ? CW'(1) : w_count_inc;
              r_timer <= '0;
              if ((r_state == S_ARMED) ? (NUM_COUNT == 1) : w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_RUN;
              end
            end else if (w_edge) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
              r_code  <= 2'b10;
            end else if (w_tmo) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
              r_code  <= 2'b01;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.STATE    = r_state;
  assign bus.COUNT    = r_count;
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.ERR      = r_err;
  assign bus.ERR_CODE = r_code;
endmodule

// File: tb/tb_step_rx.sv
// Scoreboard bench for step_rx: directed bursts push expected snapshots per cycle,
// a negedge monitor pops and compares them.
module tb_step_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  step_rx_if #(.NUM_COUNT(5)) ifc ();
  step_rx #(.NUM_COUNT(5), .MIN_GAP(3), .TIMEOUT(16)) dut (
    .CLK(clk), .RST(rst), .bus(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    string       nm;
    logic [10:0] v;
  } exp_t;
  exp_t q[$];

  function automatic logic [10:0] pack(input logic [2:0] cnt, input logic b, d, e,
                                       input logic [1:0] code, input logic [2:0] st);
    return {cnt, b, d, e, code, st};
  endfunction

  task automatic cmp(input string nm, input logic [10:0] want);
    logic [10:0] got;
    got = pack(ifc.COUNT, ifc.BUSY, ifc.DONE, ifc.ERR, ifc.ERR_CODE, ifc.STATE);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got cnt=%0d busy=%b done=%b err=%b code=%b st=%0d, want cnt=%0d busy=%b done=%b err=%b code=%b st=%0d",
               nm, cyc, got[10:8], got[7], got[6], got[5], got[4:3], got[2:0],
               want[10:8], want[7], want[6], want[5], want[4:3], want[2:0]);
    end
  endtask

  task automatic ex(input int c, input string nm, input logic [2:0] cnt, input logic b, d, e,
                    input logic [1:0] code, input logic [2:0] st);
    exp_t t;
    t.c = c; t.nm = nm; t.v = pack(cnt, b, d, e, code, st);
    q.push_back(t);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t t;
      t = q.pop_front();
      if (t.c < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL %s: expectation for cyc %0d missed (now %0d)", t.nm, t.c, cyc);
      end else begin
        cmp(t.nm, t.v);
      end
    end
  end

  task automatic burst(input int n, input logic [31:0] am, input logic [31:0] sm);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      ifc.ARM  = am[c];
      ifc.STEP = sm[c];
    end
  endtask

  initial begin
    int b;
    ifc.ARM = 1'b0; ifc.STEP = 1'b0;
    #3 cmp("reset_state", '0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Full burst, then a sixth pulse as overrun.
    b = cyc + 1;
    ex(b+1,  "b1_armed",   3'd0, 1, 0, 0, 2'b00, 3'd1);
    ex(b+3,  "b1_cnt1",    3'd1, 1, 0, 0, 2'b00, 3'd2);
    ex(b+6,  "b1_cnt2",    3'd2, 1, 0, 0, 2'b00, 3'd2);
    ex(b+9,  "b1_cnt3",    3'd3, 1, 0, 0, 2'b00, 3'd2);
    ex(b+12, "b1_cnt4",    3'd4, 1, 0, 0, 2'b00, 3'd2);
    ex(b+14, "b1_pre_done",3'd4, 1, 0, 0, 2'b00, 3'd2);
    ex(b+15, "b1_done",    3'd5, 0, 1, 0, 2'b00, 3'd3);
    ex(b+16, "b1_idle",    3'd5, 0, 0, 0, 2'b00, 3'd0);
    ex(b+17, "b1_idle2",   3'd5, 0, 0, 0, 2'b00, 3'd0);
    ex(b+18, "b1_overrun", 3'd5, 0, 0, 1, 2'b11, 3'd4);
    burst(19, 32'h1, 32'h24924);

    // Too-fast pulse, then re-arm and let it time out.
    b = cyc + 1;
    ex(b+1,  "b2_arm_clr", 3'd0, 1, 0, 0, 2'b00, 3'd1);
    ex(b+3,  "b2_cnt1",    3'd1, 1, 0, 0, 2'b00, 3'd2);
    ex(b+4,  "b2_cnt1b",   3'd1, 1, 0, 0, 2'b00, 3'd2);
    ex(b+5,  "b2_fast",    3'd1, 0, 0, 1, 2'b10, 3'd4);
    ex(b+6,  "b2_hold",    3'd1, 0, 0, 1, 2'b10, 3'd4);
    ex(b+8,  "b3_rearm",   3'd0, 1, 0, 0, 2'b00, 3'd1);
    ex(b+23, "b3_pre_tmo", 3'd0, 1, 0, 0, 2'b00, 3'd1);
    ex(b+24, "b3_timeout", 3'd0, 0, 0, 1, 2'b01, 3'd4);
    ex(b+25, "b3_hold",    3'd0, 0, 0, 1, 2'b01, 3'd4);
    burst(26, 32'h81, 32'h14);

    // STEP held high counts once, then times out.
    b = cyc + 1;
    ex(b+1,  "b5_armed",   3'd0, 1, 0, 0, 2'b00, 3'd1);
    ex(b+3,  "b5_cnt1",    3'd1, 1, 0, 0, 2'b00, 3'd2);
    ex(b+18, "b5_pre_tmo", 3'd1, 1, 0, 0, 2'b00, 3'd2);
    ex(b+19, "b5_timeout", 3'd1, 0, 0, 1, 2'b01, 3'd4);
    ex(b+21, "b5_hold",    3'd1, 0, 0, 1, 2'b01, 3'd4);
    burst(22, 32'h1, 32'h1FFFFC);

    // ARM coinciding with an edge restarts and discards the edge.
    b = cyc + 1;
    ex(b+3,  "b6_cnt1",    3'd1, 1, 0, 0, 2'b00, 3'd2);
    ex(b+6,  "b6_restart", 3'd0, 1, 0, 0, 2'b00, 3'd1);
    ex(b+9,  "b6_cnt1",    3'd1, 1, 0, 0, 2'b00, 3'd2);
    burst(10, 32'h21, 32'h124);

    // Asynchronous reset mid-burst, STEP high across release.
    b = cyc + 1;
    ex(b+9,  "b7_cnt3",    3'd3, 1, 0, 0, 2'b00, 3'd2);
    burst(11, 32'h1, 32'h124);
    #2 rst = 1'b1; ifc.STEP = 1'b1;
    #1 cmp("async_reset", '0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    b = cyc + 1;
    ex(b+0,  "rel_overrun",3'd0, 0, 0, 1, 2'b11, 3'd4);
    ex(b+2,  "rel_hold",   3'd0, 0, 0, 1, 2'b11, 3'd4);
    burst(3, 32'h0, 32'h7);
    b = cyc + 1;
    ex(b+1,  "err_rearm",  3'd0, 1, 0, 0, 2'b00, 3'd1);
    burst(3, 32'h1, 32'h0);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
